// File: rtl/cnt_seq_ctrl_pkg.sv
// cnt_seq_pkg: state encoding and direction constants shared by the sequencer
package cnt_seq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } st_t;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// cnt_seq_ctrl_if: command handshake, run controls and status of the sequencer
interface cnt_seq_ctrl_if #(parameter int N = 8, parameter int R = 4);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_start;
  logic [N-1:0] cmd_end;
  logic         cmd_dir;
  logic [R-1:0] cmd_reps;
  logic         pause;
  logic         abort;
  logic [N-1:0] cnt;
  logic         busy;
  logic         tick;
  logic         done;
  logic [R-1:0] pass_idx;
  modport master (
    output cmd_valid, cmd_start, cmd_end, cmd_dir, cmd_reps, pause, abort,
    input  cmd_ready, cnt, busy, tick, done, pass_idx
  );
  modport slave (
    input  cmd_valid, cmd_start, cmd_end, cmd_dir, cmd_reps, pause, abort,
    output cmd_ready, cnt, busy, tick, done, pass_idx
  );
endinterface

// File: rtl/cnt_seq_ctrl_updown_cnt.sv
// updown_cnt: loadable modulo up/down counter, load wins over enable
module updown_cnt #(parameter int N = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [N-1:0] ld_val,
  input  logic         en,
  input  logic         up,
  output logic [N-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (ld) cnt <= ld_val;
    else if (en) cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
endmodule

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: runs programmed multi-pass count sequences on an up/down counter
module cnt_seq_ctrl import cnt_seq_pkg::*; #(parameter int N = 8, parameter int R = 4) (
  input logic           clk,
  input logic           rst,
  cnt_seq_ctrl_if.slave bus
);
  st_t          r_state;
  logic [N-1:0] r_start, r_end;
  logic         r_dir;
  logic [R-1:0] r_reps, r_pass;
  logic [N-1:0] w_cnt;
  logic         w_run, w_term, w_more, w_ld, w_en;
  assign w_run  = r_state == ST_RUN && !bus.pause && !bus.abort;
  assign w_term = w_cnt == r_end;
  assign w_more = r_pass < r_reps;
  // reloading on the terminal cycle keeps repeated passes back-to-back
  assign w_ld   = !bus.abort && (r_state == ST_LOAD || (w_run && w_term && w_more));
  assign w_en   = w_run && !w_term;
  assign bus.cmd_ready = r_state == ST_IDLE && !rst;
  assign bus.busy      = r_state != ST_IDLE;
  assign bus.tick      = w_run && w_term;
  assign bus.done      = r_state == ST_DONE && !bus.abort;
  assign bus.pass_idx  = r_pass;
  assign bus.cnt       = w_cnt;
  updown_cnt #(.N(N)) u_cnt (
    .clk(clk), .rst(rst), .ld(w_ld), .ld_val(r_start),
    .en(w_en), .up(r_dir == DIR_UP), .cnt(w_cnt)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= ST_IDLE;
      r_start <= '0;
      r_end   <= '0;
      r_dir   <= DIR_UP;
      r_reps  <= '0;
      r_pass  <= '0;
    end else if (bus.abort) r_state <= ST_IDLE;
    else case (r_state)
      ST_IDLE: if (bus.cmd_valid) begin
        r_start <= bus.cmd_start;
        r_end   <= bus.cmd_end;
        r_dir   <= bus.cmd_dir;
        r_reps  <= bus.cmd_reps;
        r_pass  <= '0;
        r_state <= ST_LOAD;
      end
      ST_LOAD: r_state <= ST_RUN;
      ST_RUN: if (!bus.pause && w_term) begin
        if (w_more) r_pass <= r_pass + 1'b1;
        else r_state <= ST_DONE;
      end
      default: r_state <= ST_IDLE;
    endcase
endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: table-driven command vectors plus directed pause/abort/reset/handshake sequences
module tb_cnt_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cnt_seq_ctrl_if #(.N(8), .R(4)) bus();
  cnt_seq_ctrl #(.N(8), .R(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic [7:0] e;
    logic       d;
    logic [3:0] r;
    int         runs;
    int         ticks;
  } vec_t;
  vec_t vt[6];
  int n_run = 0, n_fail = 0;

  task automatic check(string name, int act, int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(logic [7:0] s, logic [7:0] e, logic d, logic [3:0] r);
    bus.cmd_valid = 1'b1;
    bus.cmd_start = s;
    bus.cmd_end   = e;
    bus.cmd_dir   = d;
    bus.cmd_reps  = r;
  endtask

  task automatic accept_and_release(logic [7:0] s, logic [7:0] e, logic d, logic [3:0] r);
    @(negedge clk); issue(s, e, d, r); #1;
    check("accept_ready", int'(bus.cmd_ready), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_start = ~s;
    bus.cmd_end   = ~e;
    bus.cmd_dir   = ~d;
    bus.cmd_reps  = '1;
    #1;
    check("load_busy", int'(bus.busy), 1);
  endtask

  task automatic run_vec(vec_t v);
    int k, ticks;
    logic got;
    ticks = 0; got = 1'b0; k = 1;
    accept_and_release(v.s, v.e, v.d, v.r);
    for (int j = 2; j <= 400 && !got; j++) begin
      @(negedge clk); #1;
      k = j;
      if (j == 2) check("vec_first_cnt", int'(bus.cnt), int'(v.s));
      if (bus.tick) ticks++;
      if (bus.done) got = 1'b1;
    end
    check("vec_done_seen", int'(got), 1);
    check("vec_done_cycle", k, 2 + v.runs);
    check("vec_ticks", ticks, v.ticks);
    check("vec_final_cnt", int'(bus.cnt), int'(v.e));
    check("vec_pass_idx", int'(bus.pass_idx), int'(v.r));
    @(negedge clk); #1;
    check("vec_ready_after", int'(bus.cmd_ready), 1);
    check("vec_busy_after", int'(bus.busy), 0);
  endtask

  initial begin
    int exp_cnt[9]  = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int exp_pass[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int exp_tick[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    logic got;
    bus.cmd_valid = 1'b0; bus.cmd_start = '0; bus.cmd_end = '0;
    bus.cmd_dir = 1'b0; bus.cmd_reps = '0; bus.pause = 1'b0; bus.abort = 1'b0;
    vt[0] = '{8'd3,   8'd6,   1'b1, 4'd0, 4,  1};
    vt[1] = '{8'd1,   8'd254, 1'b0, 4'd0, 4,  1};
    vt[2] = '{8'd0,   8'd2,   1'b1, 4'd2, 9,  3};
    vt[3] = '{8'd7,   8'd7,   1'b1, 4'd1, 2,  2};
    vt[4] = '{8'd250, 8'd2,   1'b1, 4'd0, 9,  1};
    vt[5] = '{8'd10,  8'd5,   1'b0, 4'd3, 24, 4};

    @(negedge clk); #1;
    check("rst_ready_low", int'(bus.cmd_ready), 0);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_cnt", int'(bus.cnt), 0);
    check("rst_pass", int'(bus.pass_idx), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_tick", int'(bus.tick), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_ready_high", int'(bus.cmd_ready), 1);

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // cycle-exact repeat sequence
    accept_and_release(8'd0, 8'd2, 1'b1, 4'd2);
    for (int j = 0; j < 9; j++) begin
      @(negedge clk); #1;
      check("rep_cnt", int'(bus.cnt), exp_cnt[j]);
      check("rep_pass", int'(bus.pass_idx), exp_pass[j]);
      check("rep_tick", int'(bus.tick), exp_tick[j]);
      check("rep_no_done", int'(bus.done), 0);
    end
    @(negedge clk); #1;
    check("rep_done", int'(bus.done), 1);
    @(negedge clk); #1;
    check("rep_single_done", int'(bus.done), 0);

    // pause while cnt=2 for three cycles
    accept_and_release(8'd0, 8'd5, 1'b1, 4'd0);
    got = 1'b0;
    for (int k = 2; k <= 11; k++) begin
      @(negedge clk);
      bus.pause = (k >= 4 && k <= 6);
      #1;
      if (bus.pause) begin
        check("pause_cnt", int'(bus.cnt), 2);
        check("pause_tick", int'(bus.tick), 0);
      end
      if (k == 8) check("pause_resume", int'(bus.cnt), 3);
      if (k == 10) check("pause_tick_end", int'(bus.tick), 1);
      if (k == 11) got = bus.done;
    end
    check("pause_done_cycle", int'(got), 1);
    bus.pause = 1'b0;

    // abort at cnt=4
    accept_and_release(8'd0, 8'd9, 1'b1, 4'd0);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      bus.abort = (k == 6);
      #1;
    end
    check("abort_cnt_now", int'(bus.cnt), 4);
    check("abort_tick", int'(bus.tick), 0);
    check("abort_done", int'(bus.done), 0);
    @(negedge clk); bus.abort = 1'b0; #1;
    check("abort_ready", int'(bus.cmd_ready), 1);
    check("abort_cnt_hold", int'(bus.cnt), 4);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_no_done", int'(bus.done), 0);

    // cmd_valid held through a run is only taken in IDLE
    @(negedge clk); issue(8'd0, 8'd3, 1'b1, 4'd0); #1;
    check("hs_accept", int'(bus.cmd_ready), 1);
    @(negedge clk); bus.cmd_start = 8'd5; bus.cmd_end = 8'd6; #1;
    check("hs_ready_load", int'(bus.cmd_ready), 0);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk); #1;
      if (k <= 5) check("hs_cnt", int'(bus.cnt), k - 2);
      if (k == 6) check("hs_done", int'(bus.done), 1);
    end
    @(negedge clk); #1;
    check("hs_second_ready", int'(bus.cmd_ready), 1);
    @(negedge clk); bus.cmd_valid = 1'b0; #1;
    check("hs_second_load", int'(bus.busy), 1);
    @(negedge clk); #1;
    check("hs_second_cnt", int'(bus.cnt), 5);
    got = 1'b0;
    for (int j = 0; j < 20 && !got; j++) begin
      @(negedge clk); #1;
      got = bus.done;
    end
    check("hs_second_done", int'(got), 1);

    // rst together with abort mid-run
    accept_and_release(8'd7, 8'd7, 1'b1, 4'd3);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk); #1;
    end
    check("ra_pass_before", int'(bus.pass_idx), 2);
    @(negedge clk); rst = 1'b1; bus.abort = 1'b1; #1;
    check("ra_ready_in_rst", int'(bus.cmd_ready), 0);
    @(negedge clk); rst = 1'b0; bus.abort = 1'b0; #1;
    check("ra_cnt", int'(bus.cnt), 0);
    check("ra_pass", int'(bus.pass_idx), 0);
    check("ra_busy", int'(bus.busy), 0);
    check("ra_tick", int'(bus.tick), 0);
    check("ra_done", int'(bus.done), 0);
    check("ra_ready", int'(bus.cmd_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
